// File: rtl/fifo_mem.sv
// fifo_mem: storage array behind the memory port of the generic FIFO controller.
// The controller issues write and read strobes with addresses. Read data comes back
// registered, together with a valid pulse and a never-written flag. Any strobe whose
// address is not below DEPTH sets a sticky error flag.
//
// Ports:
//   clk          in   1       clock, all state updates on posedge
//   reset        in   1       synchronous, active-high reset
//   mem_wr_en    in   1       write strobe, one word per cycle
//   mem_wr_addr  in   AWIDTH  write address
//   mem_wr_data  in   WIDTH   write data
//   mem_rd_en    in   1       read strobe, one word per cycle
//   mem_rd_addr  in   AWIDTH  read address
//   rd_data      out  WIDTH   registered read data
//   rd_valid     out  1       one-cycle pulse per read result
//   rd_uninit    out  1       qualifies rd_valid: the entry was never written since reset
//   addr_err     out  1       sticky: an address >= DEPTH was presented with a strobe
//
// Build option:
//   FIFO_MEM_OUTREG_EN  adds a second output register stage (read latency 2).
//                       When it is undefined there is one stage and the read latency is 1.

module fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   mem_wr_addr,
    input  logic [WIDTH-1:0]           mem_wr_data,
    input  logic                       mem_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   mem_rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       rd_uninit,
    output logic                       addr_err
);

    localparam int unsigned AWIDTH = $clog2(DEPTH);
    // DEPTH held one bit wider than an address, so that the range compare never overflows
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_wvld;
    logic             r_addr_err;

    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_valid;
    logic             r_s1_uninit;

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_wr_go;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_rd_uninit;

    // Address range qualification. This is constant-true when DEPTH is a power of 2.
    assign w_wr_ok = ({1'b0, mem_wr_addr} < DEPTH_W);
    assign w_rd_ok = ({1'b0, mem_rd_addr} < DEPTH_W);
    assign w_wr_go = mem_wr_en && w_wr_ok;

    // Read lookup. An out-of-range read returns zero data that is flagged uninitialised.
    always_comb begin
        w_rd_word   = '0;
        w_rd_uninit = 1'b1;
        if (w_rd_ok) begin
            w_rd_word   = r_mem[mem_rd_addr];
            w_rd_uninit = ~r_wvld[mem_rd_addr];
        end
    end

    // Storage array. It is not reset. Reads in the same cycle see the old contents.
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_mem[mem_wr_addr] <= mem_wr_data;
        end
    end

    // Per-entry written flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wvld <= '0;
        end else if (w_wr_go) begin
            r_wvld[mem_wr_addr] <= 1'b1;
        end
    end

    // Sticky address error, raised by either strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if ((mem_wr_en && !w_wr_ok) || (mem_rd_en && !w_rd_ok)) begin
            r_addr_err <= 1'b1;
        end
    end

    // First output stage. Data holds when there is no read. Valid and uninit drop to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_data   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_uninit <= 1'b0;
        end else begin
            r_s1_valid  <= mem_rd_en;
            r_s1_uninit <= mem_rd_en && w_rd_uninit;
            if (mem_rd_en) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

`ifdef FIFO_MEM_OUTREG_EN
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_valid;
    logic             r_s2_uninit;

    // Second output stage. The whole result moves through it as one unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_data   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_uninit <= 1'b0;
        end else begin
            r_s2_data   <= r_s1_data;
            r_s2_valid  <= r_s1_valid;
            r_s2_uninit <= r_s1_uninit;
        end
    end

    assign rd_data   = r_s2_data;
    assign rd_valid  = r_s2_valid;
    assign rd_uninit = r_s2_uninit;
`else
    assign rd_data   = r_s1_data;
    assign rd_valid  = r_s1_valid;
    assign rd_uninit = r_s1_uninit;
`endif

    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_fifo_mem.sv
// Directed bench for fifo_mem. It uses two instances: DEPTH=8 for the main
// behaviour and DEPTH=6 for the out-of-range address handling.
module tb_fifo_mem;

`ifdef FIFO_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;

    logic       a_wr_en, a_rd_en;
    logic [2:0] a_wr_addr, a_rd_addr;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_rd_uninit, a_addr_err;

    logic       b_wr_en, b_rd_en;
    logic [2:0] b_wr_addr, b_rd_addr;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_rd_uninit, b_addr_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fifo_mem #(.DEPTH(8), .WIDTH(8)) u8 (
        .clk(clk), .reset(reset),
        .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_uninit(a_rd_uninit),
        .addr_err(a_addr_err)
    );

    fifo_mem #(.DEPTH(6), .WIDTH(8)) u6 (
        .clk(clk), .reset(reset),
        .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_uninit(b_rd_uninit),
        .addr_err(b_addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input logic [2:0] addr, input logic [7:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
    endtask

    // Issue one read on u8 and wait until its result is on the outputs
    task automatic rd8(input logic [2:0] addr);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic rd6(input logic [2:0] addr);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        b_rd_en = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_total++;
        if ({a_rd_data, a_rd_valid, a_rd_uninit, a_addr_err} !== 11'h0)
            $display("FAIL reset_u8: got data=%h v=%b u=%b e=%b, want all 0",
                     a_rd_data, a_rd_valid, a_rd_uninit, a_addr_err);
        else n_pass++;
        n_total++;
        if ({b_rd_data, b_rd_valid, b_rd_uninit, b_addr_err} !== 11'h0)
            $display("FAIL reset_u6: got data=%h v=%b u=%b e=%b, want all 0",
                     b_rd_data, b_rd_valid, b_rd_uninit, b_addr_err);
        else n_pass++;
    endtask

    task automatic test_uninit_read();
        rd8(3'd3);
        n_total++;
        if ({a_rd_valid, a_rd_uninit, a_addr_err} !== 3'b110)
            $display("FAIL uninit_read: got v=%b u=%b e=%b, want 1 1 0",
                     a_rd_valid, a_rd_uninit, a_addr_err);
        else n_pass++;
        tick();
        n_total++;
        if ({a_rd_valid, a_rd_uninit} !== 2'b00)
            $display("FAIL uninit_pulse_end: got v=%b u=%b, want 0 0", a_rd_valid, a_rd_uninit);
        else n_pass++;
    endtask

    task automatic test_write_read();
        wr8(3'd2, 8'hA5);
        rd8(3'd2);
        n_total++;
        if ({a_rd_valid, a_rd_data, a_rd_uninit} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL write_read: got v=%b d=%h u=%b, want 1 a5 0",
                     a_rd_valid, a_rd_data, a_rd_uninit);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        wr8(3'd5, 8'h11);
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 8'h22;
        a_rd_en = 1'b1; a_rd_addr = 3'd5;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        n_total++;
        if ({a_rd_valid, a_rd_data, a_rd_uninit} !== {1'b1, 8'h11, 1'b0})
            $display("FAIL same_cycle_old: got v=%b d=%h u=%b, want 1 11 0",
                     a_rd_valid, a_rd_data, a_rd_uninit);
        else n_pass++;
        rd8(3'd5);
        n_total++;
        if (a_rd_data !== 8'h22)
            $display("FAIL same_cycle_new: got d=%h, want 22", a_rd_data);
        else n_pass++;
        // The entry was never written, so rd_uninit must use the old written flag
        a_wr_en = 1'b1; a_wr_addr = 3'd7; a_wr_data = 8'h3C;
        a_rd_en = 1'b1; a_rd_addr = 3'd7;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        n_total++;
        if ({a_rd_valid, a_rd_uninit} !== 2'b11)
            $display("FAIL same_cycle_uninit: got v=%b u=%b, want 1 1", a_rd_valid, a_rd_uninit);
        else n_pass++;
        rd8(3'd7);
        n_total++;
        if ({a_rd_data, a_rd_uninit} !== {8'h3C, 1'b0})
            $display("FAIL same_cycle_landed: got d=%h u=%b, want 3c 0", a_rd_data, a_rd_uninit);
        else n_pass++;
    endtask

    task automatic test_diff_addr();
        a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 8'h5A;
        a_rd_en = 1'b1; a_rd_addr = 3'd2;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        n_total++;
        if ({a_rd_valid, a_rd_data, a_rd_uninit} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL diff_addr_rd: got v=%b d=%h u=%b, want 1 a5 0",
                     a_rd_valid, a_rd_data, a_rd_uninit);
        else n_pass++;
        rd8(3'd1);
        n_total++;
        if ({a_rd_data, a_rd_uninit} !== {8'h5A, 1'b0})
            $display("FAIL diff_addr_wr: got d=%h u=%b, want 5a 0", a_rd_data, a_rd_uninit);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 8; i++) wr8(3'(i), 8'(8'h10 + i));
        for (int c = 0; c < 8 + LAT; c++) begin
            a_rd_en   = (c < 8);
            a_rd_addr = 3'(c);
            tick();
            if (a_rd_valid === 1'b1) pulses++;
            if (c - (LAT - 1) >= 0 && c - (LAT - 1) < 8) begin
                n_total++;
                if ({a_rd_valid, a_rd_data} !== {1'b1, 8'(8'h10 + c - (LAT - 1))})
                    $display("FAIL b2b_%0d: got v=%b d=%h, want 1 %h", c - (LAT - 1),
                             a_rd_valid, a_rd_data, 8'(8'h10 + c - (LAT - 1)));
                else n_pass++;
            end else if (c - (LAT - 1) >= 8) begin
                n_total++;
                if (a_rd_valid !== 1'b0)
                    $display("FAIL b2b_tail: got v=%b, want 0", a_rd_valid);
                else n_pass++;
            end
        end
        a_rd_en = 1'b0;
        n_total++;
        if (pulses != 8)
            $display("FAIL b2b_pulses: got %0d, want 8", pulses);
        else n_pass++;
    endtask

    task automatic test_hold();
        rd8(3'd4);
        tick();
        n_total++;
        if ({a_rd_valid, a_rd_uninit, a_rd_data} !== {2'b00, 8'h14})
            $display("FAIL hold: got v=%b u=%b d=%h, want 0 0 14",
                     a_rd_valid, a_rd_uninit, a_rd_data);
        else n_pass++;
    endtask

    task automatic test_addr_err();
        b_wr_en = 1'b1; b_wr_addr = 3'd6; b_wr_data = 8'h77;
        tick();
        b_wr_en = 1'b0;
        n_total++;
        if (b_addr_err !== 1'b1)
            $display("FAIL addr_err_set: got %b, want 1", b_addr_err);
        else n_pass++;
        repeat (3) tick();
        n_total++;
        if (b_addr_err !== 1'b1)
            $display("FAIL addr_err_sticky: got %b, want 1", b_addr_err);
        else n_pass++;
        rd6(3'd6);
        n_total++;
        if ({b_rd_valid, b_rd_data, b_rd_uninit} !== {1'b1, 8'h00, 1'b1})
            $display("FAIL oor_read: got v=%b d=%h u=%b, want 1 00 1",
                     b_rd_valid, b_rd_data, b_rd_uninit);
        else n_pass++;
        // A dropped write to address 6 must not alias onto an in-range entry
        for (int i = 0; i < 6; i++) begin
            rd6(3'(i));
            n_total++;
            if (b_rd_uninit !== 1'b1)
                $display("FAIL oor_no_alias_%0d: got u=%b, want 1", i, b_rd_uninit);
            else n_pass++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (b_addr_err !== 1'b0)
            $display("FAIL addr_err_clear: got %b, want 0", b_addr_err);
        else n_pass++;
        // A read strobe alone also raises the flag
        b_rd_en = 1'b1; b_rd_addr = 3'd7;
        tick();
        b_rd_en = 1'b0;
        n_total++;
        if (b_addr_err !== 1'b1)
            $display("FAIL addr_err_rd: got %b, want 1", b_addr_err);
        else n_pass++;
        n_total++;
        if (a_addr_err !== 1'b0)
            $display("FAIL addr_err_pow2: got %b, want 0", a_addr_err);
        else n_pass++;
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        a_rd_en = 1'b1; a_rd_addr = 3'd0;
`ifdef FIFO_MEM_OUTREG_EN
        tick();
        a_rd_en = 1'b0;
        reset = 1'b1;
        tick();
`else
        reset = 1'b1;
        tick();
        a_rd_en = 1'b0;
`endif
        if (a_rd_valid === 1'b1) pulses++;
        reset = 1'b0;
        repeat (3) begin
            tick();
            if (a_rd_valid === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 0)
            $display("FAIL reset_inflight: got %0d pulses, want 0", pulses);
        else n_pass++;
        // The written flags are cleared, so a read now reports uninit
        rd8(3'd0);
        n_total++;
        if ({a_rd_valid, a_rd_uninit} !== 2'b11)
            $display("FAIL reset_wvld: got v=%b u=%b, want 1 1", a_rd_valid, a_rd_uninit);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = 1'b0; a_rd_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = 1'b0; b_rd_addr = '0;
        test_reset();
        test_uninit_read();
        test_write_read();
        test_same_cycle();
        test_diff_addr();
        test_back_to_back();
        test_hold();
        test_addr_err();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
